// File: rtl/lsu_queue_if.sv
// lsu_queue_if: request, data-memory and response channels of the load/store queue.
// The slave modport is the queue itself; the master modport is its environment
// (XM stage, data memory and MW stage seen together).
interface lsu_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  // XM stage -> queue
  logic              req_valid_i;
  logic              req_wen_i;
  logic              req_byte_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [RD_W-1:0]   req_rd_i;
  logic              req_ready_o;

  // queue -> data memory request
  logic              mem_valid_o;
  logic              mem_wen_o;
  logic              mem_byte_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_yumi_i;

  // data memory -> queue response
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ryumi_o;

  // queue -> MW stage
  logic              resp_valid_o;
  logic              resp_is_load_o;
  logic [RD_W-1:0]   resp_rd_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_yumi_i;

  modport slave (
    input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    input  mem_yumi_i,
    input  mem_rvalid_i, mem_rdata_i,
    output mem_ryumi_o,
    output resp_valid_o, resp_is_load_o, resp_rd_o, resp_data_o,
    input  resp_yumi_i
  );

  modport master (
    output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    output mem_yumi_i,
    output mem_rvalid_i, mem_rdata_i,
    input  mem_ryumi_o,
    input  resp_valid_o, resp_is_load_o, resp_rd_o, resp_data_o,
    output resp_yumi_i
  );
endinterface

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue between the XM stage and data memory.
// Up to DEPTH ops in flight; valid/yumi handshakes on both memory channels;
// completed ops are handed to MW through a one-entry response register.
// Optional feature: define LSU_TIMEOUT_EN to enable the response watchdog
// (timeout_o); without it timeout_o is tied low.
module lsu_queue #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RD_W        = 5,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  lsu_queue_if.slave bus,
  output logic       busy_o,
  output logic       err_o,
  output logic       timeout_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;   // MSB is the wrap bit

  typedef struct packed {
    logic              wen;
    logic              byte_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t            entries [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, iss_ptr, ret_ptr;
  logic [PTR_W-1:0]  count;
  logic              outstanding;
  logic              do_accept, do_issue, do_retire;
  entry_t            iss_entry, ret_entry;
  logic [DATA_W-1:0] ret_data;

  logic              resp_valid_q;
  logic              resp_is_load_q;
  logic [RD_W-1:0]   resp_rd_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              err_q;

  // Handshake decode and queue status, all from registered pointers.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    count       = wr_ptr - ret_ptr;
    outstanding = (ret_ptr != iss_ptr);
    iss_entry   = entries[iss_ptr[IDX_W-1:0]];
    ret_entry   = entries[ret_ptr[IDX_W-1:0]];

    bus.req_ready_o = (count != PTR_W'(DEPTH));
    bus.mem_valid_o = (iss_ptr != wr_ptr);
    bus.mem_wen_o   = iss_entry.wen;
    bus.mem_byte_o  = iss_entry.byte_op;
    bus.mem_addr_o  = iss_entry.addr;
    bus.mem_wdata_o = iss_entry.wdata;
    bus.mem_ryumi_o = bus.mem_rvalid_i & outstanding & (~resp_valid_q | bus.resp_yumi_i);

    do_accept = bus.req_valid_i & bus.req_ready_o;
    do_issue  = bus.mem_valid_o & bus.mem_yumi_i;
    do_retire = bus.mem_ryumi_o;

    // Loads return the word or the zero-extended low byte; stores return 0.
    ret_data = '0;
    if (!ret_entry.wen) begin
      ret_data = ret_entry.byte_op ? {{(DATA_W-8){1'b0}}, bus.mem_rdata_i[7:0]}
                                   : bus.mem_rdata_i;
    end
  end

  // Queue pointers: alloc, issue and retire may all advance in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr  <= '0;
      iss_ptr <= '0;
      ret_ptr <= '0;
    end else begin
      if (do_accept) wr_ptr  <= wr_ptr  + PTR_W'(1);
      if (do_issue)  iss_ptr <= iss_ptr + PTR_W'(1);
      if (do_retire) ret_ptr <= ret_ptr + PTR_W'(1);
    end
  end

  // Entry storage, written on accept.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; a slot is only read between valid pointers, after it was written.
    if (do_accept) begin
      entries[wr_ptr[IDX_W-1:0]] <= '{wen:     bus.req_wen_i,
                                      byte_op: bus.req_byte_i,
                                      addr:    bus.req_addr_i,
                                      wdata:   bus.req_wdata_i,
                                      rd:      bus.req_rd_i};
    end
  end

  // Response register: loaded on retire, cleared when MW takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q   <= 1'b0;
      resp_is_load_q <= 1'b0;
      resp_rd_q      <= '0;
      resp_data_q    <= '0;
    end else if (do_retire) begin
      resp_valid_q   <= 1'b1;
      resp_is_load_q <= ~ret_entry.wen;
      resp_rd_q      <= ret_entry.rd;
      resp_data_q    <= ret_data;
    end else if (bus.resp_yumi_i) begin
      resp_valid_q   <= 1'b0;
    end
  end

  // Sticky error: a memory response arrived with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 err_q <= 1'b0;
    else if (bus.mem_rvalid_i && !outstanding) err_q <= 1'b1;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;

  // Watchdog: counts cycles with ops outstanding, restarted by each retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (do_retire)
        tmo_cnt <= '0;
      else if (outstanding && (tmo_cnt != TMO_W'(TIMEOUT_CYC)))
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_cnt == TMO_W'(TIMEOUT_CYC))
        timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_is_load_o = resp_is_load_q;
  assign bus.resp_rd_o      = resp_rd_q;
  assign bus.resp_data_o    = resp_data_q;
  assign busy_o             = (count != '0) | resp_valid_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: self-checking bench for lsu_queue.
// A reference model (accepted / issued op queues plus the expected response
// register) is advanced from the handshakes each cycle; directed sequences
// add explicit checks on the documented scenarios, then random traffic runs.
module tb_lsu_queue;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int RD_W        = 5;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 8;
`ifdef LSU_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy, err, timeout;

  lsu_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

  lsu_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W),
    .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy_o(busy), .err_o(err), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic              wen;
    logic              byte_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } op_t;

  op_t               pend_q[$];   // accepted, not yet issued
  op_t               iss_q[$];    // issued, awaiting response
  logic              m_rv = 1'b0, m_err = 1'b0, m_is_load = 1'b0;
  logic [RD_W-1:0]   m_rd = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              last_ryumi = 1'b0;
  bit                auto_dmem = 0, auto_mw = 0;

  op_t  mon_op;
  logic mon_out, mon_ready, mon_ryumi;

  always @(negedge clk) begin
    if (reset) begin
      pend_q.delete();
      iss_q.delete();
      m_rv = 1'b0; m_err = 1'b0; m_is_load = 1'b0; m_rd = '0; m_data = '0;
      last_ryumi = 1'b0;
    end else begin
      mon_out   = (iss_q.size() != 0);
      mon_ready = ((pend_q.size() + iss_q.size()) != DEPTH);
      mon_ryumi = bus.mem_rvalid_i && mon_out && (!m_rv || bus.resp_yumi_i);

      check("req_ready", bus.req_ready_o, mon_ready);
      check("mem_valid", bus.mem_valid_o, pend_q.size() != 0);
      if (pend_q.size() != 0) begin
        check("mem_addr",  bus.mem_addr_o,  pend_q[0].addr);
        check("mem_wen",   bus.mem_wen_o,   pend_q[0].wen);
        check("mem_byte",  bus.mem_byte_o,  pend_q[0].byte_op);
        check("mem_wdata", bus.mem_wdata_o, pend_q[0].wdata);
      end
      check("mem_ryumi",  bus.mem_ryumi_o,  mon_ryumi);
      check("resp_valid", bus.resp_valid_o, m_rv);
      if (m_rv) begin
        check("resp_is_load", bus.resp_is_load_o, m_is_load);
        check("resp_data",    bus.resp_data_o,    m_data);
        if (m_is_load) check("resp_rd", bus.resp_rd_o, m_rd);
      end
      check("busy", busy, ((pend_q.size() + iss_q.size()) != 0) || m_rv);
      check("err",  err,  m_err);
`ifndef LSU_TIMEOUT_EN
      check("timeout_tied", timeout, 1'b0);
`endif

      // advance the model with this cycle's handshakes
      if (bus.mem_rvalid_i && !mon_out) m_err = 1'b1;
      if (mon_ryumi) begin
        mon_op    = iss_q.pop_front();
        m_is_load = !mon_op.wen;
        m_rd      = mon_op.rd;
        if (mon_op.wen)          m_data = '0;
        else if (mon_op.byte_op) m_data = {24'h0, bus.mem_rdata_i[7:0]};
        else                     m_data = bus.mem_rdata_i;
        m_rv = 1'b1;
      end else if (bus.resp_yumi_i) begin
        m_rv = 1'b0;
      end
      if (pend_q.size() != 0 && bus.mem_yumi_i) iss_q.push_back(pend_q.pop_front());
      if (bus.req_valid_i && mon_ready) begin
        mon_op.wen     = bus.req_wen_i;
        mon_op.byte_op = bus.req_byte_i;
        mon_op.addr    = bus.req_addr_i;
        mon_op.wdata   = bus.req_wdata_i;
        mon_op.rd      = bus.req_rd_i;
        pend_q.push_back(mon_op);
      end
      last_ryumi = mon_ryumi;
    end
  end

  // Randomised data memory and MW consumer, active only when enabled.
  always @(posedge clk) begin
    #1;
    if (auto_dmem) begin
      bus.mem_yumi_i = ($urandom_range(0, 3) != 0);
      if (!(bus.mem_rvalid_i && !last_ryumi)) begin
        if (iss_q.size() != 0 && $urandom_range(0, 2) != 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = $urandom;
        end else begin
          bus.mem_rvalid_i = 1'b0;
        end
      end
    end
    if (auto_mw) bus.resp_yumi_i = ($urandom_range(0, 2) != 0);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wen, input logic byte_op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid_i = 1'b1;
    bus.req_wen_i   = wen;
    bus.req_byte_i  = byte_op;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_rd_i    = rd;
  endtask

  task automatic quiet();
    bus.req_valid_i  = 1'b0;
    bus.mem_yumi_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.resp_yumi_i  = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    quiet();
    tick();
    reset = 1'b0;
  endtask

  // Let the random memory and MW retire everything, within a cycle budget.
  task automatic drain(input int budget);
    bit done = 0;
    bus.req_valid_i = 1'b0;
    auto_dmem = 1;
    auto_mw   = 1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (pend_q.size() == 0) && (iss_q.size() == 0) && !m_rv;
    end
    auto_dmem = 0;
    auto_mw   = 0;
    check("drain_done", done, 1'b1);
    tick();
    quiet();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    bus.req_wen_i = 1'b0; bus.req_byte_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.req_rd_i = '0; bus.mem_rdata_i = '0;

    // Reset state
    @(negedge clk);
    check("rst_ready",      bus.req_ready_o,    1'b1);
    check("rst_mem_valid",  bus.mem_valid_o,    1'b0);
    check("rst_resp_valid", bus.resp_valid_o,   1'b0);
    check("rst_busy",       busy,               1'b0);
    check("rst_err",        err,                1'b0);
    check("rst_timeout",    timeout,            1'b0);
    check("rst_resp_data",  bus.resp_data_o,    32'h0);
    check("rst_resp_rd",    bus.resp_rd_o,      5'd0);
    check("rst_resp_load",  bus.resp_is_load_o, 1'b0);
    tick();
    reset = 1'b0;

    // 1. Single load, yumi in its first valid cycle, rvalid two cycles later
    tick(); req(1'b0, 1'b0, 32'h10, 32'h0, 5'd3); bus.mem_yumi_i = 1'b1;
    @(negedge clk); check("t1_no_early_valid", bus.mem_valid_o, 1'b0);
    tick(); bus.req_valid_i = 1'b0;
    @(negedge clk); check("t1_mem_valid", bus.mem_valid_o, 1'b1);
    check("t1_mem_addr", bus.mem_addr_o, 32'h10);
    tick(); bus.mem_yumi_i = 1'b0;
    tick(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk); check("t1_ryumi", bus.mem_ryumi_o, 1'b1);
    tick(); bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("t1_resp_valid", bus.resp_valid_o, 1'b1);
    check("t1_resp_rd",    bus.resp_rd_o,    5'd3);
    check("t1_resp_data",  bus.resp_data_o,  32'hDEADBEEF);
    tick(); bus.resp_yumi_i = 1'b1;
    tick(); bus.resp_yumi_i = 1'b0;
    @(negedge clk);
    check("t1_resp_clear", bus.resp_valid_o, 1'b0);
    check("t1_idle",       busy,             1'b0);

    // 2. Five back-to-back requests with the memory stalled
    for (int i = 0; i < 5; i++) begin
      tick(); req(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 5'(i));
      @(negedge clk);
      check("t2_ready", bus.req_ready_o, (i < 4) ? 1'b1 : 1'b0);
      if (i > 0) check("t2_addr_hold", bus.mem_addr_o, 32'h100);
    end
    tick(); bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("t2_addr_hold_end", bus.mem_addr_o, 32'h100);
    check("t2_full",          bus.req_ready_o, 1'b0);
    drain(200);

    // 3. Byte load zero-extension, then a store acknowledgement
    tick(); req(1'b0, 1'b1, 32'h20, 32'h0, 5'd7); bus.mem_yumi_i = 1'b1; bus.resp_yumi_i = 1'b1;
    tick(); req(1'b1, 1'b0, 32'h24, 32'hCAFEF00D, 5'd0);
    tick(); bus.req_valid_i = 1'b0;
    tick(); bus.mem_yumi_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345680;
    @(negedge clk); check("t3_ryumi_ld", bus.mem_ryumi_o, 1'b1);
    tick(); bus.mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    check("t3_byte_is_load", bus.resp_is_load_o, 1'b1);
    check("t3_byte_data",    bus.resp_data_o,    32'h00000080);
    check("t3_byte_rd",      bus.resp_rd_o,      5'd7);
    tick(); bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("t3_st_valid",   bus.resp_valid_o,   1'b1);
    check("t3_st_is_load", bus.resp_is_load_o, 1'b0);
    check("t3_st_data",    bus.resp_data_o,    32'h0);
    tick(); bus.resp_yumi_i = 1'b0;
    @(negedge clk); check("t3_idle", busy, 1'b0);

    // 4. MW back-pressure holds off the second response
    tick(); req(1'b0, 1'b0, 32'h40, 32'h0, 5'd1); bus.mem_yumi_i = 1'b1;
    tick(); req(1'b0, 1'b0, 32'h44, 32'h0, 5'd2);
    tick(); bus.req_valid_i = 1'b0;
    tick(); bus.mem_yumi_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hAAAA0001;
    tick(); bus.mem_rdata_i = 32'hBBBB0002;
    @(negedge clk); check("t4_blocked_a", bus.mem_ryumi_o, 1'b0);
    tick();
    @(negedge clk);
    check("t4_blocked_b",  bus.mem_ryumi_o, 1'b0);
    check("t4_first_data", bus.resp_data_o, 32'hAAAA0001);
    tick(); bus.resp_yumi_i = 1'b1;
    @(negedge clk); check("t4_unblocked", bus.mem_ryumi_o, 1'b1);
    tick(); bus.mem_rvalid_i = 1'b0; bus.resp_yumi_i = 1'b0;
    @(negedge clk);
    check("t4_second_data", bus.resp_data_o, 32'hBBBB0002);
    check("t4_second_rd",   bus.resp_rd_o,   5'd2);
    tick(); bus.resp_yumi_i = 1'b1;
    tick(); bus.resp_yumi_i = 1'b0;

    // Random traffic
    auto_dmem = 1;
    auto_mw   = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 1) != 0)
        req(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom, $urandom,
            5'($urandom_range(0, 31)));
      else
        bus.req_valid_i = 1'b0;
    end
    tick();
    drain(400);

    // 5a. Reset with three ops in flight
    tick(); req(1'b0, 1'b0, 32'h50, 32'h0, 5'd4); bus.mem_yumi_i = 1'b1;
    tick(); req(1'b0, 1'b0, 32'h54, 32'h0, 5'd5);
    tick(); req(1'b0, 1'b0, 32'h58, 32'h0, 5'd6);
    tick(); bus.req_valid_i = 1'b0;
    tick(); bus.mem_yumi_i = 1'b0; reset = 1'b1;
    #1;
    check("t5_rst_busy",      busy,             1'b0);
    check("t5_rst_ready",     bus.req_ready_o,  1'b1);
    check("t5_rst_mem_valid", bus.mem_valid_o,  1'b0);
    tick(); reset = 1'b0;

    // 5b. Stale response after reset -> sticky error, queue untouched
    tick(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1;
    @(negedge clk); check("t5_stale_ryumi", bus.mem_ryumi_o, 1'b0);
    tick(); bus.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("t5_err",   err,             1'b1);
    check("t5_busy",  busy,            1'b0);
    check("t5_ready", bus.req_ready_o, 1'b1);
    tick(); req(1'b1, 1'b0, 32'h70, 32'h5A5A5A5A, 5'd0);
    tick(); bus.req_valid_i = 1'b0;
    drain(100);
    check("t5_err_sticky", err, 1'b1);

    // 6. Watchdog: one issued op, no response
    do_reset();
    tick(); req(1'b0, 1'b0, 32'h60, 32'h0, 5'd9); bus.mem_yumi_i = 1'b1;
    tick(); bus.req_valid_i = 1'b0;
    tick(); bus.mem_yumi_i = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      tick();
      @(negedge clk);
      if (k == 6)  check("t6_timeout_early", timeout, 1'b0);
      if (k == 12) check("t6_timeout",       timeout, TMO_EXP);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
